lb_arbiter: RTL and testbench

Round-robin arbiter that shares one local-bus (LB) slave port, typically the generated register map, between N_MST LB masters, such as an APB bridge and an SPI bridge. The write and read channels are arbitrated independently. Each channel locks its grant to one master until that master's transaction completes. The block sits between the bus-to-LB bridges and the register map; it adds one cycle of grant latency and no data buffering.

---
 rtl/lb_arbiter_pkg.sv | 28 ++
 rtl/lb_arb_rr.sv | 61 ++++++
 rtl/lb_arbiter.sv | 102 ++++++++++
 tb/tb_lb_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_arbiter_pkg.sv
// Shared state type and round-robin pick helper for the local-bus arbiter.
package lb_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int MAX_MST = 8;
  localparam int IDX_W   = 3;

  // First set bit of req at or after ptr, scanning cyclically over the n low bits.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_MST-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_MST - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (req[idx[IDX_W-1:0]]) begin
          rr_pick = idx[IDX_W-1:0];
        end
      end
    end
  endfunction

endpackage

// File: rtl/lb_arb_rr.sv
// Per-channel round-robin grant FSM: holds one master's grant from IDLE until
// its transaction completes or the master withdraws its request.
module lb_arb_rr import lb_arbiter_pkg::*; #(
  parameter int N_MST = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MST-1:0]         req,
  input  logic                     done,
  input  logic                     abort,
  output logic                     busy,
  output logic [$clog2(N_MST)-1:0] gnt
);

  localparam int GW = $clog2(N_MST);

  arb_state_t    state_r;
  logic [GW-1:0] gnt_r;
  logic [GW-1:0] ptr_r;
  logic [GW-1:0] pick_s;
  logic [GW-1:0] next_ptr_s;

  // Candidate grant for the next IDLE cycle and the pointer value after release.
  always_comb begin
    pick_s = GW'(rr_pick(MAX_MST'(req), IDX_W'(ptr_r), N_MST));
    if (gnt_r == GW'(N_MST - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_r + GW'(1'b1);
    end
  end

  // Grant state machine; release advances the pointer past the retired master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req) begin
            gnt_r   <= pick_s;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (done || abort) begin
            state_r <= IDLE;
            ptr_r   <= next_ptr_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy = (state_r == BUSY);
  assign gnt  = gnt_r;

endmodule

// File: rtl/lb_arbiter.sv
// Shares one LB slave port between N_MST masters; write and read channels are
// arbitrated independently, with a 1-cycle grant latency and no buffering.
module lb_arbiter import lb_arbiter_pkg::*; #(
  parameter  int N_MST  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        m_lb_wen,
  input  logic [N_MST*ADDR_W-1:0] m_lb_waddr,
  input  logic [N_MST*DATA_W-1:0] m_lb_wdata,
  input  logic [N_MST*STRB_W-1:0] m_lb_wstrb,
  output logic [N_MST-1:0]        m_lb_wready,
  input  logic [N_MST-1:0]        m_lb_ren,
  input  logic [N_MST*ADDR_W-1:0] m_lb_raddr,
  output logic [N_MST*DATA_W-1:0] m_lb_rdata,
  output logic [N_MST-1:0]        m_lb_rvalid,
  output logic                    s_lb_wen,
  output logic [ADDR_W-1:0]       s_lb_waddr,
  output logic [DATA_W-1:0]       s_lb_wdata,
  output logic [STRB_W-1:0]       s_lb_wstrb,
  input  logic                    s_lb_wready,
  output logic                    s_lb_ren,
  output logic [ADDR_W-1:0]       s_lb_raddr,
  input  logic [DATA_W-1:0]       s_lb_rdata,
  input  logic                    s_lb_rvalid
);

  localparam int GW = $clog2(N_MST);

  logic          w_busy;
  logic          r_busy;
  logic [GW-1:0] w_gnt;
  logic [GW-1:0] r_gnt;
  logic          w_done;
  logic          w_abort;
  logic          r_done;
  logic          r_abort;

  assign w_done  = w_busy && m_lb_wen[w_gnt] && s_lb_wready;
  assign w_abort = w_busy && !m_lb_wen[w_gnt];
  assign r_done  = r_busy && s_lb_rvalid;
  assign r_abort = r_busy && !m_lb_ren[r_gnt];

  lb_arb_rr #(.N_MST(N_MST)) u_w_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (m_lb_wen),
    .done  (w_done),
    .abort (w_abort),
    .busy  (w_busy),
    .gnt   (w_gnt)
  );

  lb_arb_rr #(.N_MST(N_MST)) u_r_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (m_lb_ren),
    .done  (r_done),
    .abort (r_abort),
    .busy  (r_busy),
    .gnt   (r_gnt)
  );

  // Write channel routing; everything is quiet unless a grant is held.
  always_comb begin
    s_lb_wen    = 1'b0;
    s_lb_waddr  = '0;
    s_lb_wdata  = '0;
    s_lb_wstrb  = '0;
    m_lb_wready = '0;
    if (w_busy) begin
      s_lb_wen             = m_lb_wen[w_gnt];
      s_lb_waddr           = m_lb_waddr[w_gnt*ADDR_W +: ADDR_W];
      s_lb_wdata           = m_lb_wdata[w_gnt*DATA_W +: DATA_W];
      s_lb_wstrb           = m_lb_wstrb[w_gnt*STRB_W +: STRB_W];
      m_lb_wready[w_gnt]   = s_lb_wready;
    end else begin
      m_lb_wready = '0;
    end
  end

  // Read channel routing; ren drops on the completion cycle, and a stray rvalid
  // seen while idle never reaches any master.
  always_comb begin
    s_lb_ren    = 1'b0;
    s_lb_raddr  = '0;
    m_lb_rvalid = '0;
    m_lb_rdata  = '0;
    if (r_busy) begin
      s_lb_ren                            = m_lb_ren[r_gnt] && !s_lb_rvalid;
      s_lb_raddr                          = m_lb_raddr[r_gnt*ADDR_W +: ADDR_W];
      m_lb_rvalid[r_gnt]                  = s_lb_rvalid;
      m_lb_rdata[r_gnt*DATA_W +: DATA_W]  = s_lb_rdata;
    end else begin
      m_lb_rvalid = '0;
    end
  end

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter with two masters and a hand-driven slave.
module tb_lb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_lb_wen, m_lb_wready, m_lb_ren, m_lb_rvalid;
  logic [N*AW-1:0] m_lb_waddr, m_lb_raddr;
  logic [N*DW-1:0] m_lb_wdata, m_lb_rdata;
  logic [N*SW-1:0] m_lb_wstrb;
  logic          s_lb_wen, s_lb_wready, s_lb_ren, s_lb_rvalid;
  logic [AW-1:0] s_lb_waddr, s_lb_raddr;
  logic [DW-1:0] s_lb_wdata, s_lb_rdata;
  logic [SW-1:0] s_lb_wstrb;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lb_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_lb_wen    (m_lb_wen),
    .m_lb_waddr  (m_lb_waddr),
    .m_lb_wdata  (m_lb_wdata),
    .m_lb_wstrb  (m_lb_wstrb),
    .m_lb_wready (m_lb_wready),
    .m_lb_ren    (m_lb_ren),
    .m_lb_raddr  (m_lb_raddr),
    .m_lb_rdata  (m_lb_rdata),
    .m_lb_rvalid (m_lb_rvalid),
    .s_lb_wen    (s_lb_wen),
    .s_lb_waddr  (s_lb_waddr),
    .s_lb_wdata  (s_lb_wdata),
    .s_lb_wstrb  (s_lb_wstrb),
    .s_lb_wready (s_lb_wready),
    .s_lb_ren    (s_lb_ren),
    .s_lb_raddr  (s_lb_raddr),
    .s_lb_rdata  (s_lb_rdata),
    .s_lb_rvalid (s_lb_rvalid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_w(input int m, input logic en, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_lb_wen[m]            = en;
    m_lb_waddr[m*AW +: AW] = a;
    m_lb_wdata[m*DW +: DW] = d;
    m_lb_wstrb[m*SW +: SW] = s;
  endtask

  task automatic set_r(input int m, input logic en, input logic [AW-1:0] a);
    m_lb_ren[m]            = en;
    m_lb_raddr[m*AW +: AW] = a;
  endtask

  initial begin
    rst         = 1'b1;
    m_lb_wen    = '0;
    m_lb_waddr  = '0;
    m_lb_wdata  = '0;
    m_lb_wstrb  = '0;
    m_lb_ren    = '0;
    m_lb_raddr  = '0;
    s_lb_wready = 1'b0;
    s_lb_rvalid = 1'b0;
    s_lb_rdata  = '0;

    cyc(); cyc(); settle();
    check("rst_swen",    64'(s_lb_wen),    64'h0);
    check("rst_sren",    64'(s_lb_ren),    64'h0);
    check("rst_swaddr",  64'(s_lb_waddr),  64'h0);
    check("rst_mwready", 64'(m_lb_wready), 64'h0);
    check("rst_mrvalid", 64'(m_lb_rvalid), 64'h0);
    check("rst_mrdata",  64'(m_lb_rdata),  64'h0);
    rst = 1'b0;

    // Single write from m1
    cyc();
    set_w(1, 1'b1, 32'h8000_0004, 32'hdead_beef, 4'hF);
    s_lb_wready = 1'b1;
    settle();
    check("t1_idle_wen", 64'(s_lb_wen), 64'h0);
    cyc(); settle();
    check("t1_wen",     64'(s_lb_wen),    64'h1);
    check("t1_waddr",   64'(s_lb_waddr),  64'h8000_0004);
    check("t1_wdata",   64'(s_lb_wdata),  64'hdead_beef);
    check("t1_wstrb",   64'(s_lb_wstrb),  64'hF);
    check("t1_mwready", 64'(m_lb_wready), 64'h2);
    cyc();
    set_w(1, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    check("t1_after_wen",    64'(s_lb_wen),    64'h0);
    check("t1_after_wready", 64'(m_lb_wready), 64'h0);
    cyc(); settle();
    check("t1_quiet_wen", 64'(s_lb_wen), 64'h0);

    // Contention: m0 served first, m1 after one idle cycle
    set_w(0, 1'b1, 32'h0000_000c, 32'hcafe_babe, 4'h6);
    set_w(1, 1'b1, 32'h0000_0010, 32'h00ac_ce55, 4'hF);
    cyc(); settle();
    check("t2_first_wready", 64'(m_lb_wready), 64'h1);
    check("t2_first_waddr",  64'(s_lb_waddr),  64'h0c);
    check("t2_first_wdata",  64'(s_lb_wdata),  64'hcafe_babe);
    check("t2_first_wstrb",  64'(s_lb_wstrb),  64'h6);
    cyc();
    set_w(0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    check("t2_gap_wen", 64'(s_lb_wen), 64'h0);
    cyc(); settle();
    check("t2_second_wready", 64'(m_lb_wready), 64'h2);
    check("t2_second_waddr",  64'(s_lb_waddr),  64'h10);
    check("t2_second_wdata",  64'(s_lb_wdata),  64'h00ac_ce55);
    check("t2_second_wstrb",  64'(s_lb_wstrb),  64'hF);
    cyc();
    set_w(1, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    check("t2_end_wen", 64'(s_lb_wen), 64'h0);

    // Fairness: both masters keep requesting, grants must alternate 0,1,0,1...
    set_w(0, 1'b1, 32'h0000_0100, 32'h0000_1000, 4'hF);
    set_w(1, 1'b1, 32'h0000_0200, 32'h0000_2000, 4'hF);
    for (int i = 0; i < 8; i++) begin
      int m;
      logic [DW-1:0] base;
      m    = i % 2;
      base = (m == 1) ? 32'h0000_2000 : 32'h0000_1000;
      cyc(); settle();
      check("t3_gnt",  64'(m_lb_wready), 64'(2'b01 << m));
      check("t3_data", 64'(s_lb_wdata),  64'(base + 32'(i / 2)));
      cyc();
      set_w(m, 1'b1, (m == 1) ? 32'h0000_0200 : 32'h0000_0100, base + 32'(i / 2 + 1), 4'hF);
      settle();
      check("t3_gap", 64'(s_lb_wen), 64'h0);
    end
    set_w(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_w(1, 1'b0, 32'h0, 32'h0, 4'h0);

    // Long slave wait states on an m0 write while m1 waits
    s_lb_wready = 1'b0;
    set_w(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'h3);
    cyc();
    set_w(1, 1'b1, 32'h0000_0024, 32'h5566_7788, 4'hF);
    settle();
    check("t4_grant_wen",   64'(s_lb_wen),   64'h1);
    check("t4_grant_waddr", 64'(s_lb_waddr), 64'h20);
    for (int i = 0; i < 800; i++) begin
      cyc(); settle();
      check("t4_hold_addr", 64'(s_lb_waddr), 64'h20);
      check("t4_hold_data", 64'(s_lb_wdata), 64'h1122_3344);
      check("t4_hold_ctl",  64'({s_lb_wen, m_lb_wready, s_lb_wstrb}), 64'({1'b1, 2'b00, 4'h3}));
    end
    s_lb_wready = 1'b1;
    settle();
    check("t4_accept", 64'(m_lb_wready), 64'h1);
    cyc();
    set_w(0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    check("t4_gap_wen", 64'(s_lb_wen), 64'h0);
    cyc(); settle();
    check("t4_m1_wready", 64'(m_lb_wready), 64'h2);
    check("t4_m1_waddr",  64'(s_lb_waddr),  64'h24);
    cyc();
    set_w(1, 1'b0, 32'h0, 32'h0, 4'h0);

    // m1 read with wait states, m0 write in parallel
    set_r(1, 1'b1, 32'h0000_0014);
    set_w(0, 1'b1, 32'h0000_0008, 32'h0bad_f00d, 4'hF);
    settle();
    check("t5_idle_ren", 64'(s_lb_ren), 64'h0);
    cyc(); settle();
    check("t5_ren",     64'(s_lb_ren),    64'h1);
    check("t5_raddr",   64'(s_lb_raddr),  64'h14);
    check("t5_wen",     64'(s_lb_wen),    64'h1);
    check("t5_waddr",   64'(s_lb_waddr),  64'h08);
    check("t5_wready",  64'(m_lb_wready), 64'h1);
    check("t5_rvalid0", 64'(m_lb_rvalid), 64'h0);
    cyc();
    set_w(0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    check("t5_wdone_wen", 64'(s_lb_wen), 64'h0);
    check("t5_ren_hold",  64'(s_lb_ren), 64'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("t5_wait_ren",    64'(s_lb_ren),    64'h1);
      check("t5_wait_rvalid", 64'(m_lb_rvalid), 64'h0);
    end
    cyc();
    s_lb_rvalid = 1'b1;
    s_lb_rdata  = 32'hc0de_babe;
    settle();
    check("t5_rvalid",     64'(m_lb_rvalid), 64'h2);
    check("t5_rdata",      64'(m_lb_rdata),  64'hc0de_babe_0000_0000);
    check("t5_ren_forced", 64'(s_lb_ren),    64'h0);
    cyc();
    s_lb_rvalid = 1'b0;
    s_lb_rdata  = '0;
    set_r(1, 1'b0, 32'h0);
    settle();
    check("t5_after_ren",    64'(s_lb_ren),    64'h0);
    check("t5_after_rvalid", 64'(m_lb_rvalid), 64'h0);

    // Reset while the read channel is busy; late rvalid must be discarded
    set_r(1, 1'b1, 32'h0000_0018);
    cyc(); settle();
    check("t6_ren",   64'(s_lb_ren),   64'h1);
    check("t6_raddr", 64'(s_lb_raddr), 64'h18);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_ren",   64'(s_lb_ren),   64'h0);
    check("t6_rst_raddr", 64'(s_lb_raddr), 64'h0);
    s_lb_rvalid = 1'b1;
    s_lb_rdata  = 32'hbad0_bad0;
    #1;
    check("t6_rst_rvalid", 64'(m_lb_rvalid), 64'h0);
    check("t6_rst_rdata",  64'(m_lb_rdata),  64'h0);
    cyc();
    rst = 1'b0;
    set_r(1, 1'b0, 32'h0);
    settle();
    check("t6_late_rvalid", 64'(m_lb_rvalid), 64'h0);
    check("t6_late_rdata",  64'(m_lb_rdata),  64'h0);
    s_lb_rvalid = 1'b0;
    s_lb_rdata  = '0;
    s_lb_wready = 1'b0;
    set_w(0, 1'b1, 32'h0000_0030, 32'h0000_0003, 4'hF);
    set_w(1, 1'b1, 32'h0000_0034, 32'h0000_0004, 4'hF);
    set_r(0, 1'b1, 32'h0000_0040);
    set_r(1, 1'b1, 32'h0000_0044);
    cyc(); settle();
    check("t6_w_first_m0", 64'(s_lb_waddr),  64'h30);
    check("t6_r_first_m0", 64'(s_lb_raddr),  64'h40);
    check("t6_wready_low", 64'(m_lb_wready), 64'h0);
    m_lb_wen = '0;
    m_lb_ren = '0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
